jt12_kon_sched: RTL
===================

Name: jt12_kon_sched

Overview:
- Sequencer and scheduler for the FM key-on datapath.
- Generates the 24-slot operator/channel scan (cur_op, cur_ch) that the key-on shift register and the envelope pipeline consume.
- Buffers CPU writes to key-on register 0x28 in a small FIFO.
- Presents one write at a time as keyon_op/keyon_ch/up_keyon, held for exactly one full 24-slot scan so that every slot sees it.

Parameters:
- DEPTH, 2, key-on write FIFO depth in entries; must be a power of two, minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- clk_en  input  1  synthesis slot enable; all slot and issue logic advances only when high
- wr_valid  input  1  CPU key-on write request, sampled every clk edge
- wr_data  input  8  register 0x28 value: [7:4] operator mask S4..S1, [3] unused, [2:0] channel code
- wr_ready  output  1  FIFO can accept a write this cycle
- cur_op  output  2  current operator slot
- cur_ch  output  3  current channel code (0,1,2,4,5,6)
- zero  output  1  high while slot counter is 0
- keyon_op  output  4  operator mask of the write being applied
- keyon_ch  output  3  channel code of the write being applied
- up_keyon  output  1  key-on update active
- busy  output  1  up_keyon or FIFO non-empty

Behaviour:
- Reset (asynchronous, any time, including mid-hold): slot counter 0, FIFO empty, hold counter 0.
- Output values during reset: cur_op=0, cur_ch=0, zero=1, keyon_op=0, keyon_ch=0, up_keyon=0, wr_ready=1, busy=0.
- Any in-flight update is lost on reset.
- Slot counter cnt, 0..23:
  - Increments on each clk edge with clk_en=1; wraps 23->0. clk_en=0 holds all slot/issue state.
  - cur_op = cnt/6.
  - idx = cnt mod 6; cur_ch = {idx>=3, 0, idx mod 3}, giving the sequence 0,1,2,4,5,6.
  - zero = (cnt==0). All three outputs are registered.
- Write acceptance (every clk edge, independent of clk_en):
  - A write is accepted when wr_valid && wr_ready.
  - wr_ready = !full, registered from FIFO state. A write is never accepted when the FIFO is full.
  - Writes with wr_data[1:0]==2'b11 (channel codes 3, 7) are accepted (handshake completes) but discarded; they are not pushed.
  - Pushed entry = {wr_data[7:4], wr_data[2:0]}.
- Issue FSM, states IDLE and HOLD:
  - IDLE: on a clk_en edge with FIFO non-empty, pop the head. keyon_op/keyon_ch <= entry, up_keyon <= 1, hold <= 0, go to HOLD.
  - HOLD: on each clk_en edge, hold increments. When hold==23 at a clk_en edge, up_keyon <= 0 and the FSM returns to IDLE. up_keyon is therefore high for exactly 24 clk_en cycles.
  - After HOLD ends, the next entry issues no earlier than the following clk_en edge, so there is at least one slot with up_keyon=0 between updates.
  - keyon_op/keyon_ch retain their last value in IDLE.
- Latency: a write accepted at edge N into an empty FIFO while IDLE raises up_keyon at the first clk_en edge strictly after N. The pushed entry is not bypassed combinationally.
- Simultaneous push and pop in the same cycle: allowed when not full. Occupancy stays unchanged and ordering is preserved (FIFO order).
- Pointers are log2(DEPTH)+1 bits and wrap naturally. full/empty derive from pointer MSB comparison.
- busy = up_keyon || !empty, combinational from registered state.

Test Plan:
- Reset release, clk_en=1 continuous -> cur_ch sequence 0,1,2,4,5,6 repeated, with cur_op stepping 0..3 every 6 slots. zero high once per 24 cycles. up_keyon=0, wr_ready=1.
- Single write 8'hF1 while idle -> up_keyon rises on the next clk_en edge with keyon_op=4'hF, keyon_ch=1, stays high exactly 24 clk_en cycles, then falls. busy falls in the same cycle.
- Three back-to-back writes 8'h10, 8'h22, 8'h44 with DEPTH=2:
  - First issues, next two fill the FIFO; a fourth write sees wr_ready=0 until the second entry is popped.
  - Updates appear in order, each held 24 slots, separated by one idle slot.
- Write 8'hF3 then 8'hF7 -> both handshakes complete, no up_keyon pulse, busy stays 0.
- clk_en toggling 1/0 every clock -> slot counter and hold counter advance only on enabled edges. up_keyon held for 24 enabled edges (48 clocks). Writes are still accepted on disabled edges.
- Assert rst mid-HOLD (hold=10) with 1 FIFO entry pending -> immediate up_keyon=0, FIFO empty, cur_op/cur_ch=0. After release no stale update issues.

Source files
------------

// File: rtl/jt12_kon_sched_if.sv
// Key-on scheduler bus: CPU write handshake, slot-enable input and
// the slot/key-on outputs consumed by the envelope datapath.
interface jt12_kon_sched_if;
  logic       clk_en;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [1:0] cur_op;
  logic [2:0] cur_ch;
  logic       zero;
  logic [3:0] keyon_op;
  logic [2:0] keyon_ch;
  logic       up_keyon;
  logic       busy;

  modport master (
    output clk_en, wr_valid, wr_data,
    input  wr_ready, cur_op, cur_ch, zero, keyon_op, keyon_ch, up_keyon, busy
  );

  modport slave (
    input  clk_en, wr_valid, wr_data,
    output wr_ready, cur_op, cur_ch, zero, keyon_op, keyon_ch, up_keyon, busy
  );
endinterface

// File: rtl/jt12_kon_sched.sv
// Key-on sequencer: 24-slot operator/channel scan, a small FIFO for
// register 0x28 writes, and an issue FSM that holds each write on the
// key-on outputs for one full scan.
module jt12_kon_sched #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  jt12_kon_sched_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, HOLD} state_t;

  // Slot index within a channel group -> channel code 0,1,2,4,5,6
  function automatic logic [2:0] ch_code(input logic [2:0] idx);
    case (idx)
      3'd3:    ch_code = 3'd4;
      3'd4:    ch_code = 3'd5;
      3'd5:    ch_code = 3'd6;
      default: ch_code = idx;
    endcase
  endfunction

  // Slot counter kept as operator (0..3) and index (0..5) so the
  // decoded outputs fall straight out of it.
  logic [1:0] op_q, op_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] cur_ch_q, cur_ch_d;
  logic       zero_q, zero_d;

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [6:0]  mem_q [DEPTH];
  logic [6:0]  mem_d [DEPTH];
  logic        full, empty, push, pop;
  logic [6:0]  head;

  state_t     state_q, state_d;
  logic [4:0] hold_q, hold_d;
  logic       up_q, up_d;
  logic [3:0] kop_q, kop_d;
  logic [2:0] kch_q, kch_d;

  // Bit 3 of the 0x28 value carries nothing for this block.
  logic unused_wr_bit;
  assign unused_wr_bit = bus.wr_data[3];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Channel codes 3 and 7 complete the handshake but are dropped.
  assign push  = bus.wr_valid && !full && (bus.wr_data[1:0] != 2'b11);
  assign pop   = bus.clk_en && (state_q == IDLE) && !empty;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Next slot position and its registered decode
  always_comb begin
    op_d  = op_q;
    idx_d = idx_q;
    if (bus.clk_en) begin
      if (idx_q == 3'd5) begin
        idx_d = 3'd0;
        op_d  = op_q + 2'd1;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
    cur_ch_d = ch_code(idx_d);
    zero_d   = (op_d == 2'd0) && (idx_d == 3'd0);
  end

  // FIFO pointer and storage update; writes ignore clk_en
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {bus.wr_data[7:4], bus.wr_data[2:0]};
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Issue FSM: pop one entry, hold it for 24 enabled slots, then release
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    up_d    = up_q;
    kop_d   = kop_q;
    kch_d   = kch_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          kop_d   = head[6:3];
          kch_d   = head[2:0];
          up_d    = 1'b1;
          hold_d  = 5'd0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.clk_en) begin
          if (hold_q == 5'd23) begin
            up_d    = 1'b0;
            state_d = IDLE;
          end else begin
            hold_d = hold_q + 5'd1;
          end
        end
      end
    endcase
  end

  // Control state registers; an in-flight update is dropped on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= 2'd0;
      idx_q    <= 3'd0;
      cur_ch_q <= 3'd0;
      zero_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= IDLE;
      hold_q   <= 5'd0;
      up_q     <= 1'b0;
      kop_q    <= 4'd0;
      kch_q    <= 3'd0;
    end else begin
      op_q     <= op_d;
      idx_q    <= idx_d;
      cur_ch_q <= cur_ch_d;
      zero_q   <= zero_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      up_q     <= up_d;
      kop_q    <= kop_d;
      kch_q    <= kch_d;
    end
  end

  // FIFO storage holds data only; validity comes from the pointers
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.wr_ready = !full;
  assign bus.cur_op   = op_q;
  assign bus.cur_ch   = cur_ch_q;
  assign bus.zero     = zero_q;
  assign bus.keyon_op = kop_q;
  assign bus.keyon_ch = kch_q;
  assign bus.up_keyon = up_q;
  assign bus.busy     = up_q || !empty;
endmodule
